mmcm_drp_sequencer: RTL
=======================

Name: mmcm_drp_sequencer

Overview:
- Controller that reconfigures an MMCME2_ADV at run time through its DRP port.
- A requester selects one of NUM_CFG stored configurations. The block holds the MMCM in reset, performs a read-modify-write of each DRP register in that configuration, releases reset and waits for LOCKED.
- Sits beside the MMCM in the clocking top level; runs on the free-running input clock, never on an MMCM output.

Parameters:
- NUM_CFG, 4, number of stored configurations.
- REGS_PER_CFG, 8, DRP register writes per configuration.
- DRDY_TIMEOUT, 64, max cycles from den to drdy before error.
- LOCK_TIMEOUT, 65535, max cycles from reset release to locked before error.

Ports:
- clk  in  1  free-running input clock (also drives MMCM DCLK)
- rst_n  in  1  synchronous active-low reset
- cfg_req  in  1  start pulse; sampled only in IDLE
- cfg_sel  in  $clog2(NUM_CFG)  configuration index, captured with cfg_req
- cfg_busy  out  1  high from the cycle after an accepted req until DONE/ERR exits
- cfg_done  out  1  one-cycle pulse on successful lock
- cfg_err  out  1  sticky error flag; cleared by the next accepted cfg_req
- tbl_we  in  1  table write strobe
- tbl_addr  in  $clog2(NUM_CFG*REGS_PER_CFG)  entry index = cfg*REGS_PER_CFG + reg
- tbl_wdata  in  39  {addr[6:0], mask[15:0], data[15:0]}
- drp_daddr  out  7  DRP address
- drp_di  out  16  DRP write data
- drp_do  in  16  DRP read data
- drp_den  out  1  DRP enable, single-cycle
- drp_dwe  out  1  DRP write enable, valid with den
- drp_drdy  in  1  DRP ready
- mmcm_rst  out  1  drives MMCM RST
- mmcm_locked  in  1  MMCM LOCKED, treated as synchronous to clk

Behaviour:
- Reset (rst_n=0 at a clk edge) puts the FSM in IDLE and sets all outputs to 0 except mmcm_rst=0; the table contents are not cleared.
- Reset mid-sequence aborts immediately: den=0 and mmcm_rst=0 next cycle.
- Table writes are accepted in any state, but writes into the active configuration while busy are undefined usage.
- FSM states and transitions:
  - IDLE: on cfg_req, capture cfg_sel, set reg_idx=0, clear cfg_err, go to ASSERT_RST.
  - ASSERT_RST: mmcm_rst=1 (held through WAIT_WR of the last register). Go to RD.
  - RD: den=1, dwe=0, daddr=entry.addr, for exactly one cycle. Go to WAIT_RD.
  - WAIT_RD: on drdy, latch rmw = (drp_do & mask) | (data & ~mask), then go to WR.
  - WR: den=1, dwe=1, di=rmw, for one cycle. Go to WAIT_WR.
  - WAIT_WR: on drdy, if reg_idx==REGS_PER_CFG-1 go to RELEASE, else increment reg_idx and go to RD.
  - RELEASE: mmcm_rst=0, clear the timer, go to WAIT_LOCK.
  - WAIT_LOCK: on locked=1, go to DONE.
  - DONE: cfg_done=1 for one cycle, then IDLE.
  - ERR: cfg_err=1, mmcm_rst=0, then IDLE.
- Mask convention: mask bit 1 = keep the existing register bit.
- Minimum per-register cost: 4 cycles, with drdy arriving the cycle after den.
- Timeouts:
  - WAIT_RD and WAIT_WR each use a counter started at den; reaching DRDY_TIMEOUT without drdy goes to ERR.
  - WAIT_LOCK reaching LOCK_TIMEOUT goes to ERR.
- Boundary rules:
  - drdy outside a WAIT state is ignored.
  - cfg_req while busy is ignored (no queueing).
  - cfg_req together with rst_n=0: reset wins.
  - cfg_sel >= NUM_CFG is clamped to NUM_CFG-1.
  - A table entry with addr==7'h7F is skipped (no DRP access, goes straight to the next register); an all-skip configuration still pulses the MMCM reset.

Optional Feature:
- MMCM_DRP_READBACK_EN defined: after each WAIT_WR, extra states RB and WAIT_RB re-read the same address. If drp_do != rmw, go to ERR. Adds 2+ cycles per register.
- Not defined: no readback; the FSM goes from WAIT_WR straight to next/RELEASE.

Decomposition:
- Package mmcm_drp_pkg holds:
  - the state enum;
  - DRP_ADDR_W=7 and DRP_DATA_W=16;
  - SKIP_ADDR=7'h7F;
  - the entry struct {addr, mask, data} and its width of 39.
- Sub-module mmcm_drp_cfg_table: a synchronous-write, combinational-read register array of NUM_CFG*REGS_PER_CFG entries; the read index is {cfg_q, reg_idx}.

Test Plan:
- Basic: load cfg 1 with 8 entries (addr 0x08+i, mask 0x1000, data 0x0041+i). DRP model returns 0xFFFF with drdy 1 cycle after den. Pulse cfg_req with sel=1. Expect 8 reads, then writes di=0x1041+i in address order; mmcm_rst=1 throughout. Drop locked for 10 cycles after release, then raise it: one cfg_done pulse, cfg_busy low the next cycle.
- DRDY timeout: the model never asserts drdy on the 3rd read. Expect cfg_err=1 exactly DRDY_TIMEOUT cycles after that den, mmcm_rst=0, return to IDLE, no cfg_done.
- Lock timeout: set LOCK_TIMEOUT=100 and hold locked=0. Expect cfg_err 100 cycles after RELEASE. A new cfg_req clears cfg_err.
- Skip/busy: entries 2–7 set to addr 0x7F. Expect exactly 2 RMW accesses. cfg_req pulsed mid-sequence with sel=2 is ignored; the DRP addresses still come from cfg 1.
- Reset mid-write: drive rst_n=0 in the WR state. Next cycle den=0, dwe=0, mmcm_rst=0, busy=0; table contents are retained and a rerun succeeds.
- Readback (MMCM_DRP_READBACK_EN): the model corrupts the 4th write (stores value^0x0001). Expect cfg_err after the 4th readback and no further DRP accesses.

Source files
------------

// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP reconfiguration sequencer.
// Also used by builds that define MMCM_DRP_READBACK_EN (adds the StRb/StWaitRb states).
package mmcm_drp_pkg;

    localparam int unsigned DRP_ADDR_W = 7;
    localparam int unsigned DRP_DATA_W = 16;

    localparam logic [DRP_ADDR_W-1:0] SKIP_ADDR = 7'h7F;

    typedef struct packed {
        logic [DRP_ADDR_W-1:0] addr;
        logic [DRP_DATA_W-1:0] mask;
        logic [DRP_DATA_W-1:0] data;
    } drp_entry_t;

    localparam int unsigned ENTRY_W = $bits(drp_entry_t);

    typedef logic [3:0] state_t;

    localparam state_t StIdle      = 4'd0;
    localparam state_t StAssertRst = 4'd1;
    localparam state_t StRd        = 4'd2;
    localparam state_t StWaitRd    = 4'd3;
    localparam state_t StWr        = 4'd4;
    localparam state_t StWaitWr    = 4'd5;
    localparam state_t StRb        = 4'd6;
    localparam state_t StWaitRb    = 4'd7;
    localparam state_t StRelease   = 4'd8;
    localparam state_t StWaitLock  = 4'd9;
    localparam state_t StDone      = 4'd10;
    localparam state_t StErr       = 4'd11;

    // Mask bit set keeps the bit currently in the DRP register.
    function automatic logic [DRP_DATA_W-1:0] rmw_merge(input logic [DRP_DATA_W-1:0] cur,
                                                        input logic [DRP_DATA_W-1:0] mask,
                                                        input logic [DRP_DATA_W-1:0] data);
        return (cur & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/mmcm_drp_cfg_table.sv
// Configuration table: synchronous write, combinational read, contents survive reset.
module mmcm_drp_cfg_table
    import mmcm_drp_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic       clk_i,
    input  logic       we_i,
    input  logic [AW-1:0] waddr_i,
    input  drp_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output drp_entry_t rdata_o
);

    drp_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mmcm_drp_sequencer.sv
// Run-time MMCME2_ADV reconfiguration over DRP: hold reset, read-modify-write each table entry,
// release reset, wait for lock. Define MMCM_DRP_READBACK_EN to verify each write by re-reading.
module mmcm_drp_sequencer
    import mmcm_drp_pkg::*;
#(
    parameter int unsigned NUM_CFG      = 4,
    parameter int unsigned REGS_PER_CFG = 8,
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    localparam int unsigned CFG_W  = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1,
    localparam int unsigned TBL_AW = (NUM_CFG * REGS_PER_CFG > 1) ?
                                     $clog2(NUM_CFG * REGS_PER_CFG) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_req_i,
    input  logic [CFG_W-1:0]      cfg_sel_i,
    output logic                  cfg_busy_o,
    output logic                  cfg_done_o,
    output logic                  cfg_err_o,
    input  logic                  tbl_we_i,
    input  logic [TBL_AW-1:0]     tbl_addr_i,
    input  logic [ENTRY_W-1:0]    tbl_wdata_i,
    output logic [DRP_ADDR_W-1:0] drp_daddr_o,
    output logic [DRP_DATA_W-1:0] drp_di_o,
    input  logic [DRP_DATA_W-1:0] drp_do_i,
    output logic                  drp_den_o,
    output logic                  drp_dwe_o,
    input  logic                  drp_drdy_i,
    output logic                  mmcm_rst_o,
    input  logic                  mmcm_locked_i
);

    localparam int unsigned REG_W   = (REGS_PER_CFG > 1) ? $clog2(REGS_PER_CFG) : 1;
    localparam int unsigned TMR_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_t                state_q, state_d, adv_state;
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic [REG_W-1:0]      reg_idx_q, reg_idx_d, adv_idx;
    logic [DRP_DATA_W-1:0] rmw_q, rmw_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  err_q, err_d;
    logic [TBL_AW-1:0]     rd_idx;
    drp_entry_t            entry;
    logic                  skip, last_reg, drdy_expired, lock_expired;

    assign rd_idx = TBL_AW'(32'(cfg_q) * REGS_PER_CFG + 32'(reg_idx_q));

    mmcm_drp_cfg_table #(
        .DEPTH(NUM_CFG * REGS_PER_CFG)
    ) u_table (
        .clk_i   (clk_i),
        .we_i    (tbl_we_i),
        .waddr_i (tbl_addr_i),
        .wdata_i (tbl_wdata_i),
        .raddr_i (rd_idx),
        .rdata_o (entry)
    );

    assign skip     = (entry.addr == SKIP_ADDR);
    assign last_reg = (32'(reg_idx_q) == REGS_PER_CFG - 1);

    // tmr_q holds the number of cycles elapsed since the den (or release) cycle.
    assign drdy_expired = (32'(tmr_q) >= DRDY_TIMEOUT - 1);
    assign lock_expired = (32'(tmr_q) >= LOCK_TIMEOUT - 1);

    assign adv_state = last_reg ? StRelease : StRd;
    assign adv_idx   = last_reg ? reg_idx_q : reg_idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        reg_idx_d = reg_idx_q;
        rmw_d     = rmw_q;
        tmr_d     = tmr_q;
        err_d     = err_q;
        case (state_q)
            StIdle: begin
                if (cfg_req_i) begin
                    cfg_d     = (32'(cfg_sel_i) >= NUM_CFG) ? CFG_W'(NUM_CFG - 1) : cfg_sel_i;
                    reg_idx_d = '0;
                    err_d     = 1'b0;
                    state_d   = StAssertRst;
                end
            end
            StAssertRst: state_d = StRd;
            StRd: begin
                tmr_d = TMR_W'(1);
                if (skip) begin
                    state_d   = adv_state;
                    reg_idx_d = adv_idx;
                end else begin
                    state_d = StWaitRd;
                end
            end
            StWaitRd: begin
                if (drp_drdy_i) begin
                    rmw_d   = rmw_merge(drp_do_i, entry.mask, entry.data);
                    state_d = StWr;
                end else if (drdy_expired) begin
                    state_d = StErr;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StWr: begin
                tmr_d   = TMR_W'(1);
                state_d = StWaitWr;
            end
            StWaitWr: begin
                if (drp_drdy_i) begin
`ifdef MMCM_DRP_READBACK_EN
                    state_d = StRb;
`else
                    state_d   = adv_state;
                    reg_idx_d = adv_idx;
`endif
                end else if (drdy_expired) begin
                    state_d = StErr;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`ifdef MMCM_DRP_READBACK_EN
            StRb: begin
                tmr_d   = TMR_W'(1);
                state_d = StWaitRb;
            end
            StWaitRb: begin
                if (drp_drdy_i) begin
                    if (drp_do_i != rmw_q) begin
                        state_d = StErr;
                    end else begin
                        state_d   = adv_state;
                        reg_idx_d = adv_idx;
                    end
                end else if (drdy_expired) begin
                    state_d = StErr;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`endif
            StRelease: begin
                tmr_d   = TMR_W'(1);
                state_d = StWaitLock;
            end
            StWaitLock: begin
                if (mmcm_locked_i) begin
                    state_d = StDone;
                end else if (lock_expired) begin
                    state_d = StErr;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (state_d == StErr) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cfg_q     <= '0;
            reg_idx_q <= '0;
            rmw_q     <= '0;
            tmr_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            reg_idx_q <= reg_idx_d;
            rmw_q     <= rmw_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
        end
    end

    assign drp_den_o   = ((state_q == StRd) && !skip) || (state_q == StWr) || (state_q == StRb);
    assign drp_dwe_o   = (state_q == StWr);
    assign drp_daddr_o = drp_den_o ? entry.addr : '0;
    assign drp_di_o    = drp_dwe_o ? rmw_q : '0;
    assign mmcm_rst_o  = (state_q == StAssertRst) || (state_q == StRd) || (state_q == StWaitRd) ||
                         (state_q == StWr) || (state_q == StWaitWr) || (state_q == StRb) ||
                         (state_q == StWaitRb);
    assign cfg_busy_o  = (state_q != StIdle);
    assign cfg_done_o  = (state_q == StDone);
    assign cfg_err_o   = err_q;

endmodule
